// File: rtl/network_interface_local_pkg.sv
// Shared definitions for the network interface slice: flit field positions,
// field widths, the statistics counter width and a saturating increment.
package network_interface_local_pkg;

  localparam int unsigned DST_LSB     = 0;
  localparam int unsigned SRC_LSB     = 3;
  localparam int unsigned PAYLOAD_LSB = 6;
  localparam int unsigned ADDR_W      = 3;
  localparam int unsigned PAYLOAD_W   = 26;
  localparam int unsigned CNT_W       = 8;
  localparam int unsigned FLIT_W      = PAYLOAD_LSB + PAYLOAD_W;

  // Counter increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic             en);
    return (en && (cnt != '1)) ? cnt + CNT_W'(1) : cnt;
  endfunction

endpackage

// File: rtl/network_interface_local_fifo.sv
// ni_sync_fifo: single-clock show-ahead FIFO, power-of-two depth, extra
// pointer bit distinguishes full from empty, asynchronous active-low reset.
// Ports: clk, rst_n, push/wdata (write side), pop/rdata (read side, rdata is
// the head entry), full, empty. Callers must not push when full unless a pop
// happens on the same edge, and must not pop when empty.
module ni_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Storage is cleared too so the head output reads zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/network_interface_local.sv
// network_interface_local: links one processing element to the local port of
// its mesh router. Core sends (tx_valid/tx_ready, tx_dst, tx_payload) become
// single 32-bit flits {payload, NODE_ADDR, dst} queued in a transmit FIFO and
// injected as rtr_data_out/rtr_valid_out whenever rtr_full_in is low. Flits
// from the router (rtr_data_in/rtr_valid_in, no back-pressure) are captured
// into a receive FIFO drained by the core via rx_valid/rx_ready, exposing
// rx_src and rx_payload of the head flit. rx_drop_cnt counts flits lost to a
// full receive FIFO; rx_misroute_cnt counts flits rejected by the destination
// check, which exists only when NI_RX_ADDR_CHECK_EN is defined (otherwise
// every flit is accepted subject to space and the count is tied to zero).
module network_interface_local
  import network_interface_local_pkg::*;
#(
  parameter logic [ADDR_W-1:0] NODE_ADDR = 3'b000,
  parameter int unsigned       TX_DEPTH  = 4,
  parameter int unsigned       RX_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [ADDR_W-1:0]    tx_dst,
  input  logic [PAYLOAD_W-1:0] tx_payload,
  output logic [FLIT_W-1:0]    rtr_data_out,
  output logic                 rtr_valid_out,
  input  logic                 rtr_full_in,
  input  logic [FLIT_W-1:0]    rtr_data_in,
  input  logic                 rtr_valid_in,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [ADDR_W-1:0]    rx_src,
  output logic [PAYLOAD_W-1:0] rx_payload,
  output logic [CNT_W-1:0]     rx_drop_cnt,
  output logic [CNT_W-1:0]     rx_misroute_cnt
);

  logic              tx_full, tx_empty, tx_push, tx_pop;
  logic [FLIT_W-1:0] tx_flit;
  logic              rx_full, rx_empty, rx_push, rx_pop;
  logic [FLIT_W-1:0] rx_head;
  logic              addr_ok, rx_space, rx_drop;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  // Transmit path
  assign tx_ready      = !tx_full;
  assign tx_push       = tx_valid && !tx_full;
  assign tx_flit       = {tx_payload, NODE_ADDR, tx_dst};
  assign rtr_valid_out = !tx_empty && !rtr_full_in;
  assign tx_pop        = rtr_valid_out;

  ni_sync_fifo #(.WIDTH(FLIT_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push),
    .wdata (tx_flit),
    .pop   (tx_pop),
    .rdata (rtr_data_out),
    .full  (tx_full),
    .empty (tx_empty)
  );

  // Receive path
  assign rx_valid   = !rx_empty;
  assign rx_pop     = rx_valid && rx_ready;
  assign rx_src     = rx_head[SRC_LSB +: ADDR_W];
  assign rx_payload = rx_head[PAYLOAD_LSB +: PAYLOAD_W];
  // A full FIFO still has room when its head leaves on the same edge.
  assign rx_space   = !rx_full || rx_pop;

`ifdef NI_RX_ADDR_CHECK_EN
  logic             misroute;
  logic [CNT_W-1:0] misroute_cnt_q, misroute_cnt_d;

  assign addr_ok  = (rtr_data_in[DST_LSB +: ADDR_W] == NODE_ADDR);
  assign misroute = rtr_valid_in && !addr_ok;

  always_comb begin
    misroute_cnt_d = sat_inc(misroute_cnt_q, misroute);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misroute_cnt_q <= '0;
    else        misroute_cnt_q <= misroute_cnt_d;
  end

  assign rx_misroute_cnt = misroute_cnt_q;
`else
  assign addr_ok         = 1'b1;
  assign rx_misroute_cnt = '0;
`endif

  // Misrouted flits never reach the space test, so they are not also drops.
  assign rx_push = rtr_valid_in && addr_ok && rx_space;
  assign rx_drop = rtr_valid_in && addr_ok && !rx_space;

  ni_sync_fifo #(.WIDTH(FLIT_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_push),
    .wdata (rtr_data_in),
    .pop   (rx_pop),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  always_comb begin
    drop_cnt_d = sat_inc(drop_cnt_q, rx_drop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign rx_drop_cnt = drop_cnt_q;

endmodule

// File: doc/network_interface_local.md
# network_interface_local

Network interface connecting one processing element to the local port of its mesh router. It packs core send requests into 32-bit single-flit packets and injects them into the router's local input FIFO under its full flag. It also captures flits leaving the router's local output, which cannot be back-pressured, into a receive FIFO that the core drains with a valid/ready handshake.

## Interface

- NODE_ADDR, 3'b000, this node's mesh address; inserted as the source field and used for the destination check.
- TX_DEPTH, 4, transmit FIFO depth in flits; must be a power of two, minimum 2.
- RX_DEPTH, 4, receive FIFO depth in flits; must be a power of two, minimum 2.

Reset and clocking (already decided): reset rst_n, asynchronous, active-low; clock clk.

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- tx_valid  in  1  core send request
- tx_ready  out  1  transmit FIFO can accept a flit
- tx_dst  in  3  destination node address
- tx_payload  in  26  payload bits
- rtr_data_out  out  32  flit to the router's local data input
- rtr_valid_out  out  1  flit valid; the router writes it on this clock edge
- rtr_full_in  in  1  router local input FIFO full
- rtr_data_in  in  32  flit from the router's local data output
- rtr_valid_in  in  1  router local output valid
- rx_valid  out  1  received flit available to the core
- rx_ready  in  1  core consumes the flit
- rx_src  out  3  source address of the head flit
- rx_payload  out  26  payload of the head flit
- rx_drop_cnt  out  8  saturating count of flits lost because the receive FIFO was full
- rx_misroute_cnt  out  8  saturating count of flits discarded by the destination check

## Operation

- Flit format: [2:0] destination, [5:3] source, [31:6] payload. The router routes on bits [2:0].
- TX push: when tx_valid and tx_ready are both high at an edge, the flit {tx_payload, NODE_ADDR, tx_dst} is written to the transmit FIFO. tx_ready is the inverse of the FIFO full flag.
- The transmit FIFO is show-ahead: rtr_data_out always presents the head flit.
- rtr_valid_out is high when the transmit FIFO is not empty and rtr_full_in is low. This output is combinational from rtr_full_in.
- TX pop: the head flit is removed at any edge where rtr_valid_out is high. A flit is never presented while rtr_full_in is high, so the router never receives a write while full.
- RX write: on rtr_valid_in, the flit is written to the receive FIFO. Space is counted as "not full, or a pop happens in the same cycle".
- If rtr_valid_in arrives with no space, the flit is dropped and rx_drop_cnt increments. The counter saturates at 255.
- RX read: rx_valid is the inverse of the receive FIFO empty flag. rx_src and rx_payload are taken from the head flit. The head flit pops when rx_valid and rx_ready are both high.
- Self-addressed sends (tx_dst equal to NODE_ADDR) are legal; the router returns them through the local output.
- Reset values: tx_ready 1, rtr_valid_out 0, rtr_data_out 0, rx_valid 0, rx_src 0, rx_payload 0, both counters 0. Both FIFO pointers are cleared.
- Reset asserted mid-operation discards every buffered flit in both FIFOs immediately.

## Timing

- TX latency: a flit accepted at edge t appears with rtr_valid_out high in cycle t+1, provided the FIFO was empty and rtr_full_in is low. It is written into the router at the end of cycle t+1.
- While rtr_full_in stays high, the head flit is held stable and nothing is written to the router.
- Throughput is 1 flit per cycle in each direction.
- RX latency: a flit captured at edge t gives rx_valid in cycle t+1.
- Full transmit FIFO with a simultaneous pop: tx_ready stays low in that cycle, and the push is taken in the next cycle.
- Full receive FIFO with a simultaneous rx pop and rtr_valid_in: the incoming flit is accepted and nothing is dropped.
- Counter saturation: a counter at 255 stays at 255.

## Configuration

- NI_RX_ADDR_CHECK_EN defined:
  - Incoming flits whose bits [2:0] differ from NODE_ADDR are discarded and never enter the receive FIFO.
  - rx_misroute_cnt increments for each discarded flit.
  - The destination check takes precedence over the drop check: a misrouted flit arriving while the receive FIFO is full counts only as misroute.
- NI_RX_ADDR_CHECK_EN undefined:
  - Every flit is accepted, subject to space.
  - rx_misroute_cnt is tied to 0.

## Structure

- Shared package holds:
  - flit field position constants: DST_LSB 0, SRC_LSB 3, PAYLOAD_LSB 6;
  - widths: ADDR_W 3, PAYLOAD_W 26;
  - the counter width CNT_W 8.
- One sub-module, ni_sync_fifo, instantiated twice (transmit and receive). It is a single-clock, show-ahead, parameterised-depth FIFO with an extra pointer bit for full/empty detection and asynchronous reset.

## Test plan

- Single send: NODE_ADDR 2, tx_dst 5, tx_payload 0x0ABCDEF, rtr_full_in 0 -> rtr_valid_out high for one cycle, the cycle after acceptance, with rtr_data_out 0x2AF37BD5.
- Back-pressure: hold rtr_full_in high and push 4 flits -> tx_ready low after the 4th flit, rtr_valid_out stays low. Release rtr_full_in -> the 4 flits leave in order on 4 consecutive cycles.
- RX overflow: rx_ready 0, drive 6 consecutive flits addressed to NODE_ADDR -> 4 are stored and rx_drop_cnt equals 2. Raise rx_ready -> the first 4 flits are read in order.
- Simultaneous pop and arrive with the receive FIFO full: no drop, and rx_valid stays high.
- With NI_RX_ADDR_CHECK_EN, NODE_ADDR 2, drive a flit with destination 3 -> rx_valid stays 0 and rx_misroute_cnt equals 1. Without the macro, the same flit is delivered.
- Assert reset with 3 flits buffered in each FIFO -> all outputs return to their reset values, and afterwards no stale flit appears on either side.
